// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the fifo write-port arbiter and its read-side sibling.
package fifo_wr_arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  // Source-id width: at least one bit even for a single requester.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set bit of i_req at or after i_start, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_index
);

  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned c;
      logic [W-1:0] ci;
      c = 32'(i_start) + i;
      if (c >= N) c = c - N;
      ci = W'(c);
      if (!o_found && i_req[ci]) begin
        o_found = 1'b1;
        o_index = ci;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among N_REQ valid/ready producers.
// Define FIFO_WR_ARB_PRIO0_EN to give requester 0 absolute priority at arbitration.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  localparam int ID_W      = id_width(N_REQ)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [N_REQ-1:0]            o_req_ready,
  input  logic                        i_fifo_full,
  output logic                        o_fifo_wr_en,
  output logic [ID_W+DATA_WIDTH-1:0]  o_fifo_data,
  output logic [ID_W-1:0]             o_grant_id,
  output logic                        o_busy
);

  localparam int BC_W = $clog2(BURST_LEN) + 1;

  arb_state_t       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant;
  logic [BC_W-1:0]  beat_cnt;

  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic [ID_W-1:0]  sel_idx;
  logic [ID_W-1:0]  next_ptr;
  logic             granted;
  logic             accept;
  logic             last_beat;

  rr_pick #(.N(N_REQ), .W(ID_W)) u_pick (
    .i_req   (i_req_valid),
    .i_start (rr_ptr),
    .o_found (pick_found),
    .o_index (pick_idx)
  );

`ifdef FIFO_WR_ARB_PRIO0_EN
  // Requester 0 overrides the rotation; pick_found already covers its valid.
  assign sel_idx = i_req_valid[0] ? '0 : pick_idx;
`else
  assign sel_idx = pick_idx;
`endif

  always_comb begin
    granted     = (state == ARB_GRANT) && !i_rst;
    accept      = granted && i_req_valid[grant] && !i_fifo_full;
    last_beat   = (beat_cnt == BC_W'(BURST_LEN - 1));
    next_ptr    = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
    o_req_ready = '0;
    if (granted) o_req_ready[grant] = !i_fifo_full;
  end

  assign o_fifo_wr_en = accept;
  assign o_fifo_data  = {grant, i_req_data[grant*DATA_WIDTH +: DATA_WIDTH]};
  assign o_grant_id   = grant;
  assign o_busy       = (state == ARB_GRANT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      beat_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      if (pick_found) begin
        grant    <= sel_idx;
        beat_cnt <= '0;
        state    <= ARB_GRANT;
      end
    end else begin
      // Early release (valid low, even under full) and burst completion both rotate.
      if (!i_req_valid[grant] || (accept && last_beat)) begin
        state <= ARB_IDLE;
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (grant != '0) rr_ptr <= next_ptr;
`else
        rr_ptr <= next_ptr;
`endif
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of one fifo instance among N_REQ producers, e.g. branch-metric units feeding the traceback buffer of the Viterbi decoder.
- Each producer offers data with a valid/ready handshake.
- The arbiter grants one producer at a time for a burst of up to BURST_LEN words.
- It drives the fifo write port with the data tagged by source ID, and honours the fifo full flag.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, payload width per requester
BURST_LEN, 4, maximum words accepted per grant before re-arbitration (>=1)

Ports:
i_clk  input  1  clock; all logic on the rising edge
i_rst  input  1  reset, synchronous and active-high
i_req_valid  input  N_REQ  per-requester data valid
i_req_data  input  N_REQ*DATA_WIDTH  packed payloads; requester k in bits [k*DATA_WIDTH +: DATA_WIDTH]
o_req_ready  output  N_REQ  per-requester accept; at most one bit high
i_fifo_full  input  1  fifo full flag
o_fifo_wr_en  output  1  fifo write enable
o_fifo_data  output  ID_W+DATA_WIDTH  {source id, payload}; ID_W = max(1, clog2(N_REQ))
o_grant_id  output  ID_W  current owner; valid while o_busy
o_busy  output  1  grant active (state GRANT)

Behaviour:
- Synchronous reset state: state=IDLE, rr_ptr=0, grant=0, beat_cnt=0.
- Synchronous reset outputs: o_busy=0, o_grant_id=0, o_req_ready=0, o_fifo_wr_en=0.
- Reset asserted mid-burst aborts the burst. No write occurs in the reset cycle.
- State IDLE:
  - Search i_req_valid starting at rr_ptr, wrapping modulo N_REQ.
  - First valid found k: register grant=k, beat_cnt=0, go to GRANT next cycle.
  - No valid: stay in IDLE.
  - Arbitration costs exactly one cycle; no writes occur in IDLE.
- State GRANT, combinational:
  - accept = i_req_valid[grant] && !i_fifo_full.
  - o_req_ready[grant] = !i_fifo_full; all other ready bits = 0.
  - o_fifo_wr_en = accept.
  - o_fifo_data = {grant, i_req_data[grant]}.
- Transfer rule: a word transfers on every edge where accept=1. On each such edge beat_cnt increments.
- GRANT -> IDLE, with rr_ptr <= (grant+1) mod N_REQ, when either:
  - accept && beat_cnt==BURST_LEN-1 (burst complete), or
  - !i_req_valid[grant] (requester released early; no transfer that cycle).
- i_fifo_full high with valid held: stall in GRANT. beat_cnt is held and no timeout applies.
- Valid dropping in the same cycle as full is treated as release.
- Max throughput: BURST_LEN words per BURST_LEN+1 cycles.
- Fairness: a continuously requesting producer waits at most (N_REQ-1)*(BURST_LEN+1) granted-cycles, excluding full stalls.
- Requesters must hold data stable while valid && !ready. Data changes are not checked.
- Counter widths:
  - beat_cnt is clog2(BURST_LEN)+1 bits.
  - rr_ptr and grant are ID_W bits; wrap uses explicit compare against N_REQ-1, not natural overflow (N_REQ may be non-power-of-2).

Optional Feature:
FIFO_WR_ARB_PRIO0_EN:
- Defined: requester 0 is high priority. In IDLE, if i_req_valid[0]=1 it wins regardless of rr_ptr. rr_ptr is not updated after a requester-0 burst. Other requesters remain round-robin among themselves.
- Undefined: pure round-robin as above. No priority logic is synthesised.

Decomposition:
- Package fifo_wr_arbiter_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  - function id_width(int n) returning max(1, clog2(n)).
- Sub-module rr_pick: combinational rotate-priority encoder, inputs (req vector, start ptr), outputs (found, index). It is reused by the later read-side scheduler.

Test Plan:
1. Reset, then all valid=0 for 10 cycles -> o_busy=0, o_fifo_wr_en never high, o_req_ready=0.
2. N_REQ=4, BURST_LEN=4; req1 alone valid with data 0x10..0x17 -> writes {1,0x10}..{1,0x13}, one idle cycle, then {1,0x14}..{1,0x17}; wr_en high 8 of 10 cycles.
3. All four valid continuously from rr_ptr=0 -> grant order 0,1,2,3,0. Each burst is exactly 4 writes with the correct ID tag.
4. Req2 granted; i_fifo_full=1 for 3 cycles after beat 1 -> wr_en=0 and ready[2]=0 during stall; beat_cnt held; burst resumes and completes with 4 total writes, no loss or duplication.
5. Req3 drops valid after 2 beats -> return to IDLE, rr_ptr=0, next grant to the lowest valid index at or after 0.
6. Assert i_rst mid-burst (beat 2) -> next cycle o_busy=0, rr_ptr=0, no write in the reset cycle. With FIFO_WR_ARB_PRIO0_EN defined, req0 and req2 both valid at rr_ptr=2 -> req0 granted first.
